// File: rtl/multdiv_unit.sv
// Multicycle signed multiply/divide unit beside the ALU in execute.
// Magnitude shift-add / restoring divide, one bit per cycle, fixed 33-cycle latency.
module multdiv_unit #(
  parameter int WIDTH       = 32,
  parameter int RSTATUS_MUL = 4,
  parameter int RSTATUS_DIV = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [4:0]       rd_in,
  output logic             busy,
  output logic             result_rdy,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic [WIDTH-1:0] status_code,
  output logic [4:0]       rd_out
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [2*WIDTH-1:0] NEG_LIMIT = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [2*WIDTH-1:0] POS_LIMIT = NEG_LIMIT - 1'b1;
  localparam logic [WIDTH-1:0]   MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t state_q, state_d;

  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [4:0]         rd_q;
  // wa_q: shifting multiplicand (MUL) or dividend/quotient register (DIV)
  logic [2*WIDTH-1:0] wa_q;
  logic [WIDTH-1:0]   wb_q;
  // acc_q: product accumulator (MUL) or partial remainder (DIV)
  logic [2*WIDTH-1:0] acc_q;

  logic [WIDTH-1:0]   result_q, status_q;
  logic               exc_q;
  logic [4:0]         rd_out_q;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  logic last, start, can_start;
  assign last      = (cnt_q == CW'(WIDTH));
  assign start     = ctrl_mult | ctrl_div;
  assign can_start = (state_q == S_IDLE) || (state_q == S_DONE);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (ctrl_mult)     state_d = S_MUL;
        else if (ctrl_div) state_d = S_DIV;
        else               state_d = S_IDLE;
      end
      S_MUL:   if (last) state_d = S_DONE;
      S_DIV:   if (last) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy       = 1'b0;
    result_rdy = 1'b0;
    case (state_q)
      S_MUL, S_DIV: busy = 1'b1;
      S_DONE: begin
        busy       = 1'b1;
        result_rdy = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------- step / finalize datapath ----------------
  logic [2*WIDTH-1:0] mul_acc_d;
  logic [WIDTH:0]     div_trial, div_sub;
  logic               div_ge;
  logic               neg;
  logic               mul_ovf, div_exc;
  logic [WIDTH-1:0]   mul_res, div_res;

  always_comb begin
    mul_acc_d = acc_q + (wb_q[0] ? wa_q : '0);
    div_trial = {acc_q[WIDTH-1:0], wa_q[WIDTH-1]};
    div_sub   = div_trial - {1'b0, wb_q};
    div_ge    = (div_trial >= {1'b0, wb_q});
    neg       = a_q[WIDTH-1] ^ b_q[WIDTH-1];
    // A negative product may reach magnitude 2^(W-1); a positive one may not
    mul_ovf   = neg ? (acc_q > NEG_LIMIT) : (acc_q > POS_LIMIT);
    mul_res   = neg ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    div_exc   = (b_q == '0) || ((a_q == MOST_NEG) && (b_q == '1));
    div_res   = neg ? -wa_q[WIDTH-1:0] : wa_q[WIDTH-1:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rd_q     <= '0;
      wa_q     <= '0;
      wb_q     <= '0;
      acc_q    <= '0;
      result_q <= '0;
      status_q <= '0;
      exc_q    <= 1'b0;
      rd_out_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start && can_start) begin
            a_q   <= operand_a;
            b_q   <= operand_b;
            rd_q  <= rd_in;
            cnt_q <= '0;
            acc_q <= '0;
            wa_q  <= {{WIDTH{1'b0}}, mag(operand_a)};
            wb_q  <= mag(operand_b);
          end
        end
        S_MUL: begin
          if (!last) begin
            acc_q <= mul_acc_d;
            wa_q  <= {wa_q[2*WIDTH-2:0], 1'b0};
            wb_q  <= {1'b0, wb_q[WIDTH-1:1]};
            cnt_q <= cnt_q + CW'(1);
          end else begin
            exc_q    <= mul_ovf;
            result_q <= mul_ovf ? '0 : mul_res;
            status_q <= mul_ovf ? WIDTH'(RSTATUS_MUL) : '0;
            rd_out_q <= rd_q;
          end
        end
        S_DIV: begin
          if (!last) begin
            acc_q <= {{WIDTH{1'b0}}, (div_ge ? div_sub[WIDTH-1:0] : div_trial[WIDTH-1:0])};
            wa_q  <= {{WIDTH{1'b0}}, wa_q[WIDTH-2:0], div_ge};
            cnt_q <= cnt_q + CW'(1);
          end else begin
            exc_q    <= div_exc;
            result_q <= div_exc ? '0 : div_res;
            status_q <= div_exc ? WIDTH'(RSTATUS_DIV) : '0;
            rd_out_q <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign result      = result_q;
  assign exception   = exc_q;
  assign status_code = status_q;
  assign rd_out      = rd_out_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: hand-computed vectors, latency, busy-ignore,
// back-to-back issue and mid-operation reset.
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_mult, ctrl_div;
  logic [31:0] operand_a, operand_b;
  logic [4:0]  rd_in;
  logic        busy, result_rdy, exception;
  logic [31:0] result, status_code;
  logic [4:0]  rd_out;

  int n_cmp = 0;
  int n_err = 0;

  multdiv_unit #(.WIDTH(32), .RSTATUS_MUL(4), .RSTATUS_DIV(5)) dut (
    .clock(clock), .reset(reset),
    .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
    .operand_a(operand_a), .operand_b(operand_b), .rd_in(rd_in),
    .busy(busy), .result_rdy(result_rdy), .result(result),
    .exception(exception), .status_code(status_code), .rd_out(rd_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a start at a negedge; returns at the negedge right after the start edge
  // with strobes cleared and operands scrambled.
  task automatic issue(input logic m, input logic d, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    @(negedge clock);
    ctrl_mult = m; ctrl_div = d;
    operand_a = a; operand_b = b; rd_in = rd;
    @(negedge clock);
    ctrl_mult = 1'b0; ctrl_div = 1'b0;
    operand_a = ~a; operand_b = b ^ 32'h5A5A_0001; rd_in = ~rd;
  endtask

  task automatic do_op(input string tag, input logic m, input logic d,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] er, input logic ee, input logic [31:0] es,
                       input int pulse_at);
    int pulses = 0;
    int rdy_at = -1;
    issue(m, d, a, b, rd);
    chk({tag, " busy_after_start"}, busy, 1);
    for (int k = 1; k <= 34; k++) begin
      if (k == pulse_at) begin
        ctrl_div = 1'b1; operand_a = 32'd100; operand_b = 32'd0;
      end
      @(negedge clock);
      ctrl_div = 1'b0;
      if (result_rdy) begin pulses++; rdy_at = k; end
      if (k == 33) begin
        chk({tag, " result"}, result, er);
        chk({tag, " exception"}, exception, ee);
        chk({tag, " status"}, status_code, es);
        chk({tag, " rd_out"}, rd_out, ee ? 5'd0 + rd : rd);
      end
    end
    chk({tag, " rdy_pulses"}, pulses, 1);
    chk({tag, " rdy_time"}, rdy_at, 33);
    chk({tag, " busy_fall"}, busy, 0);
    chk({tag, " result_held"}, result, er);
  endtask

  initial begin
    int pulses;
    reset = 1'b1; ctrl_mult = 1'b0; ctrl_div = 1'b0;
    operand_a = '0; operand_b = '0; rd_in = '0;
    repeat (3) @(negedge clock);
    chk("reset busy", busy, 0);
    chk("reset rdy", result_rdy, 0);
    chk("reset result", result, 0);
    chk("reset exc", exception, 0);
    chk("reset status", status_code, 0);
    chk("reset rd_out", rd_out, 0);
    reset = 1'b0;

    do_op("mul 7*-3",       1, 0, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 0, 0, -1);
    do_op("mul ovf",        1, 0, 32'd65536,    32'd65536,     5'd6,  32'h0,         1, 4, -1);
    do_op("mul min",        1, 0, 32'hFFFF_0000, 32'd32768,    5'd7,  32'h8000_0000, 0, 0, -1);
    do_op("div -7/2",       0, 1, 32'hFFFF_FFF9, 32'd2,        5'd8,  32'hFFFF_FFFD, 0, 0, -1);
    do_op("div max/1",      0, 1, 32'h7FFF_FFFF, 32'd1,        5'd9,  32'h7FFF_FFFF, 0, 0, -1);
    do_op("div by 0",       0, 1, 32'd123,      32'd0,         5'd10, 32'h0,         1, 5, -1);
    do_op("div min/-1",     0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h0,        1, 5, -1);

    // Reset mid-divide while a prior exception is still held
    issue(0, 1, 32'd100, 32'd7, 5'd3);
    repeat (15) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst rdy", result_rdy, 0);
    chk("midrst exc", exception, 0);
    @(negedge clock);
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (result_rdy) pulses++;
    end
    chk("midrst no_rdy", pulses, 0);
    chk("midrst idle", busy, 0);

    do_op("mul after rst",  1, 0, 32'd9,        32'd11,        5'd2,  32'd99,        0, 0, -1);
    do_op("mul busy-ign",   1, 0, 32'd5,        32'hFFFF_FFFB, 5'd12, 32'hFFFF_FFE7, 0, 0, 10);
    do_op("both strobes",   1, 1, 32'd6,        32'd7,         5'd13, 32'd42,        0, 0, -1);

    // Back-to-back: new divide issued on the edge DONE returns to IDLE
    issue(1, 0, 32'd3, 32'd4, 5'd14);
    repeat (33) @(negedge clock);
    chk("b2b first rdy", result_rdy, 1);
    chk("b2b first result", result, 32'd12);
    ctrl_div = 1'b1; operand_a = 32'hFFFF_FF9C; operand_b = 32'd7; rd_in = 5'd15;
    @(negedge clock);
    ctrl_div = 1'b0; operand_a = '0; operand_b = '0;
    chk("b2b busy cont", busy, 1);
    chk("b2b held", result, 32'd12);
    repeat (33) @(negedge clock);
    chk("b2b second rdy", result_rdy, 1);
    chk("b2b second result", result, 32'hFFFF_FFF2);
    chk("b2b second rd", rd_out, 5'd15);
    @(negedge clock);
    chk("b2b busy fall", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Multicycle signed multiply/divide unit in the execute stage, alongside the single-cycle ALU.
- Consumes the same decoded operand pair the decoder presents to the ALU (rs value, rt value) plus the destination register number.
- Returns a 32-bit result, an exception flag and an rstatus code to the writeback path.
- The processor stalls fetch while busy is high.

Parameters:
- WIDTH, 32, operand/result width in bits.
- RSTATUS_MUL, 4, rstatus code written to $30 on multiply exception.
- RSTATUS_DIV, 5, rstatus code written to $30 on divide exception.

Ports:
- clock  input  1  processor clock, rising-edge active.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- ctrl_mult  input  1  start a multiply; sampled at the rising edge.
- ctrl_div  input  1  start a divide; sampled at the rising edge.
- operand_a  input  WIDTH  multiplicand / dividend (rs value), signed.
- operand_b  input  WIDTH  multiplier / divisor (rt value), signed.
- rd_in  input  5  destination register of the issuing instruction.
- busy  output  1  high while an operation is in flight.
- result_rdy  output  1  one-cycle pulse: result, exception, status and rd_out are valid.
- result  output  WIDTH  low 32 bits of the product, or the quotient.
- exception  output  1  overflow or divide-by-zero on this result.
- status_code  output  WIDTH  RSTATUS_MUL/RSTATUS_DIV when exception is high, else 0.
- rd_out  output  5  latched rd_in; writeback uses $30 instead when exception is high.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal counter, accumulators and latches 0.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - ctrl_mult=1 -> MUL. ctrl_div=1 -> DIV.
  - Both high -> MUL wins and ctrl_div is dropped.
  - On start, latch operand_a, operand_b and rd_in, and clear the counter.
- MUL: unsigned shift-add on operand magnitudes, one bit per cycle, 32 cycles. Then DONE.
- DIV: restoring division on magnitudes, one quotient bit per cycle, 32 cycles. Then DONE.
- DONE:
  - Apply sign correction: product negated if signs differ; quotient negated if signs differ; remainder discarded.
  - Drive result_rdy=1 for exactly one cycle, then return to IDLE.
- Latency: start sampled at edge T. busy goes high after edge T. result_rdy is high between edges T+33 and T+34; busy falls after edge T+34. Latency is fixed at 33 for every case, including divide-by-zero.
- Outputs result, exception, status_code and rd_out hold their value until the next DONE or reset. Only result_rdy is pulsed.
- Multiply exception: set if the full 64-bit signed product is outside [-2^31, 2^31-1]. On exception, result=0 and status_code=RSTATUS_MUL.
- Divide exception: set if operand_b==0, or if operand_a==32'h80000000 with operand_b==-1. On exception, result=0 and status_code=RSTATUS_DIV.
- Division truncates toward zero.
- ctrl_mult/ctrl_div while busy: ignored, with no effect on the in-flight operation.
- A start may be sampled at the edge where DONE returns to IDLE; the new operation begins on that edge.
- Operand inputs may change after the start edge without effect, since only the latched copies are used.
- Reset mid-operation: immediate return to IDLE. busy, result_rdy and exception drop asynchronously. No result_rdy pulse is produced for the aborted operation.

Test Plan:
- Multiply: ctrl_mult pulse, a=7, b=-3, rd=5 -> busy for 34 cycles; result_rdy at T+33 with result=32'hFFFFFFEB (-21), exception=0, status_code=0, rd_out=5.
- Multiply overflow: a=65536, b=65536 -> result_rdy at T+33, result=0, exception=1, status_code=4. Then a=-65536, b=32768 -> result=32'h80000000, exception=0.
- Divide: a=-7, b=2 -> result=32'hFFFFFFFD (-3). Then a=2147483647, b=1 -> result=2147483647, exception=0.
- Divide exceptions: b=0 -> result=0, exception=1, status_code=5 at T+33. Separately, a=32'h80000000, b=-1 -> same response.
- Busy rule: a ctrl_div pulse at T+10 during a multiply -> ignored; a single result_rdy at T+33 carries the product. Both strobes high in IDLE -> multiply result only.
- Reset: assert reset at T+15 mid-divide -> busy=0 immediately, no result_rdy. A new multiply issued after reset completes normally with the full 33-cycle latency.
